// File: rtl/spi_master_mcs.sv
// spi_master_mcs: SPI master with internal TX/RX FIFOs, NUM_CS chip selects,
// programmable SCLK divider, full-duplex transfers and a re-triggerable
// device reset generator (wrst).
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   wdata, wr, full   TX FIFO write side (wr while full is dropped)
//   rdata, rd, empty  RX FIFO read side, show-ahead (rdata valid when !empty)
//   len, cs_sel, op   transaction setup, captured when work is accepted
//   work, busy        start request / transaction or device reset running
//   dev_rst_req       re-trigger the wrst sequence
//   sclk, mosi, miso  SPI bus, scsn active-low chip selects
//   wrst              active-low device reset
//   spi_mode[1:0]     {CPOL, CPHA}, present only with SPI_MODE_SEL_EN defined
//
// Handshake: a FIFO write is taken on any cycle with wr=1 and full=0; an RX
// word is consumed on any cycle with rd=1 and empty=0. work is a request that
// is taken only on a cycle where the FSM is IDLE, len!=0 and no device reset
// sequence runs; busy rises on the following cycle and falls when the FSM
// returns to IDLE and the reset sequence is done.
//
// Optional macro SPI_MODE_SEL_EN adds spi_mode; without it the bus is fixed
// to mode 0.

module spi_mcs_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         push,
  output logic         full,
  output logic [W-1:0] dout,
  input  logic         pop,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == DEPTH_C);
  assign empty   = (cnt == '0);
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module spi_master_mcs #(
  parameter int DATA       = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int NUM_CS     = 2,
  parameter int CLK_DIV    = 2,
  parameter int WRST_DELAY = 25,
  parameter int WRST_LEN   = 5,
  localparam int CSW       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DATA-1:0] wdata,
  input  logic            wr,
  output logic            full,
  output logic [DATA-1:0] rdata,
  input  logic            rd,
  output logic            empty,
  input  logic [15:0]     len,
  input  logic [CSW-1:0]  cs_sel,
  input  logic            op,
`ifdef SPI_MODE_SEL_EN
  input  logic [1:0]      spi_mode,
`endif
  input  logic            work,
  output logic            busy,
  input  logic            dev_rst_req,
  output logic            sclk,
  output logic            mosi,
  input  logic            miso,
  output logic [NUM_CS-1:0] scsn,
  output logic            wrst
);
  localparam int DIVW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW      = (DATA > 1) ? $clog2(DATA) : 1;
  localparam int SEQ_END = WRST_DELAY + WRST_LEN;
  localparam int SEQW    = $clog2(SEQ_END + 1);
  localparam logic [SEQW-1:0] SEQ_LAST = SEQW'(SEQ_END - 1);
  localparam logic [SEQW-1:0] SEQ_DLY  = SEQW'(WRST_DELAY);

  typedef enum logic [2:0] {IDLE, SETUP, LOAD, SHIFT, STORE, HOLD, GAP} state_t;
  state_t state, state_n;

  logic [DIVW-1:0] div_cnt;
  logic [BW-1:0]   bit_cnt;
  logic            lvl;          // SCLK phase before CPOL: 0 idle, 1 after leading edge
  logic [15:0]     words_left;
  logic [CSW-1:0]  cur_cs;
  logic            cur_op;
  logic [DATA-1:0] shreg, rxsh, load_word;
  logic            cpol, cpha;
  logic            seq_active, seq_active_n;
  logic [SEQW-1:0] seq_cnt, seq_cnt_n;

  logic            tx_empty, rx_full;
  logic [DATA-1:0] tx_rdata;
  logic            accept, div_last, bit_last, lead_edge, trail_edge;
  logic            launch, sample, load_go, tx_pop, rx_push;

  spi_mcs_fifo #(.W(DATA), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .din(wdata), .push(wr), .full(full),
    .dout(tx_rdata), .pop(tx_pop), .empty(tx_empty)
  );

  spi_mcs_fifo #(.W(DATA), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .din(rxsh), .push(rx_push), .full(rx_full),
    .dout(rdata), .pop(rd), .empty(empty)
  );

  assign accept     = (state == IDLE) && work && (len != '0) && !seq_active;
  assign div_last   = (div_cnt == DIVW'(CLK_DIV - 1));
  assign bit_last   = (bit_cnt == BW'(DATA - 1));
  assign lead_edge  = (state == SHIFT) && div_last && !lvl;
  assign trail_edge = (state == SHIFT) && div_last && lvl;
  assign launch     = cpha ? lead_edge : trail_edge;
  assign sample     = cpha ? trail_edge : lead_edge;
  // Write-only waits for TX data; full-duplex never waits for TX (dummy zero
  // word) but must not start a word it could not store in RX.
  assign load_go    = (state == LOAD) && (cur_op ? !rx_full : !tx_empty);
  assign tx_pop     = load_go && !tx_empty;
  assign load_word  = tx_empty ? '0 : tx_rdata;
  assign rx_push    = (state == STORE) && cur_op;
  assign sclk       = lvl ^ cpol;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP:   if (div_last) state_n = LOAD;
      LOAD:    if (load_go) state_n = SHIFT;
      SHIFT:   if (trail_edge && bit_last) state_n = STORE;
      STORE:   state_n = (words_left == 16'd1) ? HOLD : LOAD;
      HOLD:    if (div_last) state_n = GAP;
      GAP:     if (div_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Device reset sequencer: seq_cnt runs 0..SEQ_END-1 while active; wrst is
  // low for the last WRST_LEN counts. A request while active is ignored.
  always_comb begin
    seq_active_n = seq_active;
    seq_cnt_n    = seq_cnt;
    if (seq_active) begin
      if (seq_cnt == SEQ_LAST) seq_active_n = 1'b0;
      else                     seq_cnt_n    = seq_cnt + 1'b1;
    end else if (dev_rst_req) begin
      seq_active_n = 1'b1;
      seq_cnt_n    = '0;
    end
  end

  always_comb begin
    scsn = '1;
    if (state inside {SETUP, LOAD, SHIFT, STORE, HOLD}) begin
      for (int i = 0; i < NUM_CS; i++) begin
        if (cur_cs == CSW'(i)) scsn[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      bit_cnt    <= '0;
      lvl        <= 1'b0;
      words_left <= '0;
      cur_cs     <= '0;
      cur_op     <= 1'b0;
      shreg      <= '0;
      rxsh       <= '0;
      mosi       <= 1'b0;
      busy       <= 1'b0;
      seq_active <= 1'b1;
      seq_cnt    <= '0;
      wrst       <= 1'b1;
    end else begin
      div_cnt <= ((state_n != state) || div_last) ? '0 : div_cnt + 1'b1;
      if (accept) begin
        words_left <= len;
        cur_cs     <= cs_sel;
        cur_op     <= op;
      end
      if (load_go) begin
        bit_cnt <= '0;
        lvl     <= 1'b0;
        if (cpha) begin
          shreg <= load_word;
        end else begin
          // CPHA=0: first bit must be on mosi before the first leading edge.
          mosi  <= load_word[DATA-1];
          shreg <= load_word << 1;
        end
      end
      if (lead_edge) lvl <= 1'b1;
      if (trail_edge) begin
        lvl     <= 1'b0;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (launch) begin
        mosi  <= shreg[DATA-1];
        shreg <= shreg << 1;
      end
      if (sample) rxsh <= {rxsh[DATA-2:0], miso};
      if (state == STORE) words_left <= words_left - 1'b1;
      busy       <= (state_n != IDLE) || seq_active_n;
      seq_active <= seq_active_n;
      seq_cnt    <= seq_cnt_n;
      wrst       <= !(seq_active_n && (seq_cnt_n >= SEQ_DLY));
    end
  end

`ifdef SPI_MODE_SEL_EN
  always_ff @(posedge clk) begin
    if (rst)         {cpol, cpha} <= 2'b00;
    else if (accept) {cpol, cpha} <= spi_mode;
  end
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif
endmodule

// File: tb/tb_spi_master_mcs.sv
module tb_spi_master_mcs;
  localparam int DATA    = 8;
  localparam int NUM_CS  = 2;
  localparam int CLK_DIV = 2;

  logic              clk = 1'b0;
  logic              rst, wr, rd, op, work, dev_rst_req;
  logic [DATA-1:0]   wdata, rdata;
  logic              full, empty, busy, sclk, mosi, miso, wrst;
  logic [15:0]       len;
  logic [0:0]        cs_sel;
  logic [NUM_CS-1:0] scsn;

  logic [NUM_CS+DATA-1:0] exp_q[$];
  logic [DATA-1:0]        rx_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign miso = mosi;  // loopback

  spi_master_mcs dut (
    .clk(clk), .rst(rst), .wdata(wdata), .wr(wr), .full(full),
    .rdata(rdata), .rd(rd), .empty(empty), .len(len), .cs_sel(cs_sel),
    .op(op), .work(work), .busy(busy), .dev_rst_req(dev_rst_req),
    .sclk(sclk), .mosi(mosi), .miso(miso), .scsn(scsn), .wrst(wrst)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_tx(input logic [DATA-1:0] d);
    wdata = d;
    wr = 1'b1;
    cyc(1);
    wr = 1'b0;
  endtask

  task automatic pop_rx();
    rd = 1'b1;
    cyc(1);
    rd = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin
      cyc(1);
      n++;
    end
    check(name, busy, 1'b0);
  endtask

  task automatic start(input logic [15:0] l, input logic o, input logic c);
    wait_idle(200, "pre_start_idle");
    len = l;
    op = o;
    cs_sel = c;
    work = 1'b1;
    cyc(1);
    work = 1'b0;
    check("busy_rise", busy, 1'b1);
  endtask

  // Monitor: assembles mosi words on sclk rising edges, checks sclk high
  // time, and checks every RX word the bench pops.
  logic            prev_sclk = 1'b0;
  int              nbits = 0;
  int              hi = 0;
  logic [DATA-1:0] sh = '0;

  always @(negedge clk) begin
    if (scsn == '1) nbits = 0;
    if (sclk && !prev_sclk) begin
      sh = {sh[DATA-2:0], mosi};
      nbits++;
      if (nbits == DATA) begin
        nbits = 0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_word: unexpected word 0x%0h scsn %b", sh, scsn);
        end else begin
          check("spi_word", {scsn, sh}, exp_q.pop_front());
        end
      end
    end
    if (sclk) hi++;
    else begin
      if (prev_sclk && scsn != '1) check("sclk_high", hi, CLK_DIV);
      hi = 0;
    end
    prev_sclk = sclk;
    if (rd && !empty) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_word: unexpected pop 0x%0h", rdata);
      end else begin
        check("rx_word", rdata, rx_q.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_hi;
    rst = 1'b1; wr = 1'b0; rd = 1'b0; work = 1'b0; dev_rst_req = 1'b0;
    wdata = '0; len = '0; op = 1'b0; cs_sel = '0;
    cyc(3);
    rst = 1'b0;

    // Power-on: reset values, wrst low cycles 25..29, work at cycle 10 ignored.
    for (int n = 0; n < 35; n++) begin
      if (n == 0) begin
        check("rst_scsn", scsn, 2'b11);
        check("rst_sclk", sclk, 1'b0);
        check("rst_mosi", mosi, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_empty", empty, 1'b1);
      end
      if (n == 10) begin
        len = 16'd1; op = 1'b0; cs_sel = 1'b1; work = 1'b1;
      end
      if (n == 11) work = 1'b0;
      if (n == 12) check("por_scsn", scsn, 2'b11);
      check("wrst_por", wrst, (n >= 25 && n <= 29) ? 1'b0 : 1'b1);
      if (n >= 1) check("busy_por", busy, (n < 30) ? 1'b1 : 1'b0);
      cyc(1);
    end

    // Write-only, two words on CS1.
    push_tx(8'hA5);
    push_tx(8'h3C);
    exp_q.push_back({2'b01, 8'hA5});
    exp_q.push_back({2'b01, 8'h3C});
    start(16'd2, 1'b0, 1'b1);
    wait_idle(300, "t1_done");
    check("t1_rx_empty", empty, 1'b1);
    check("t1_words_left", exp_q.size(), 0);

    // Full duplex, TX runs dry after one word: dummy zeros.
    push_tx(8'h11);
    exp_q.push_back({2'b10, 8'h11});
    exp_q.push_back({2'b10, 8'h00});
    exp_q.push_back({2'b10, 8'h00});
    rx_q.push_back(8'h11);
    rx_q.push_back(8'h00);
    rx_q.push_back(8'h00);
    start(16'd3, 1'b1, 1'b0);
    wait_idle(300, "t2_done");
    repeat (3) pop_rx();
    check("t2_rx_empty", empty, 1'b1);
    check("t2_rx_left", rx_q.size(), 0);

    // TX full after 8 writes, 9th dropped; two passes exercise pointer wrap.
    for (int i = 0; i < 9; i++) begin
      push_tx(8'h10 + 8'(i));
      if (i == 6) check("t3_not_full", full, 1'b0);
      if (i >= 7) check("t3_full", full, 1'b1);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b01, 8'h10 + 8'(i)});
    start(16'd8, 1'b0, 1'b1);
    wait_idle(600, "t3_done1");
    check("t3_drained", full, 1'b0);
    for (int i = 0; i < 8; i++) begin
      push_tx(8'h80 + 8'(i));
      exp_q.push_back({2'b01, 8'h80 + 8'(i)});
    end
    check("t3_full2", full, 1'b1);
    start(16'd8, 1'b0, 1'b1);
    wait_idle(600, "t3_done2");
    check("t3_words_left", exp_q.size(), 0);

    // RX backpressure: len=10 full duplex with no reads stalls at 8 words.
    for (int i = 0; i < 8; i++) begin
      push_tx(8'h40 + 8'(i));
      exp_q.push_back({2'b10, 8'h40 + 8'(i)});
      rx_q.push_back(8'h40 + 8'(i));
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({2'b10, 8'h00});
      rx_q.push_back(8'h00);
    end
    start(16'd10, 1'b1, 1'b0);
    cyc(450);
    check("t4_busy", busy, 1'b1);
    check("t4_scsn", scsn, 2'b10);
    check("t4_sclk", sclk, 1'b0);
    check("t4_stall_words", exp_q.size(), 2);
    seen_hi = 1'b0;
    repeat (20) begin
      if (sclk) seen_hi = 1'b1;
      cyc(1);
    end
    check("t4_stall", seen_hi, 1'b0);
    pop_rx();
    pop_rx();
    wait_idle(300, "t4_done");
    repeat (8) pop_rx();
    check("t4_rx_empty", empty, 1'b1);
    check("t4_rx_left", rx_q.size(), 0);

    // dev_rst_req while idle: fresh 25+5 sequence with busy high.
    dev_rst_req = 1'b1;
    cyc(1);
    dev_rst_req = 1'b0;
    for (int n = 0; n < 35; n++) begin
      check("wrst_req", wrst, (n >= 25 && n <= 29) ? 1'b0 : 1'b1);
      check("busy_req", busy, (n < 30) ? 1'b1 : 1'b0);
      cyc(1);
    end

    // rst during the 3rd word of a 5-word transfer.
    for (int i = 0; i < 5; i++) push_tx(8'h51 + 8'(i));
    exp_q.push_back({2'b01, 8'h51});
    exp_q.push_back({2'b01, 8'h52});
    start(16'd5, 1'b0, 1'b1);
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
        cyc(1);
        n++;
      end
      check("t6_two_words", exp_q.size(), 0);
    end
    cyc(8);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("t6_scsn", scsn, 2'b11);
    check("t6_sclk", sclk, 1'b0);
    check("t6_busy", busy, 1'b0);
    check("t6_full", full, 1'b0);
    check("t6_empty", empty, 1'b1);
    check("t6_mosi", mosi, 1'b0);
    check("t6_wrst", wrst, 1'b1);
    cyc(2);
    // TX was flushed: the next word out must be the new one.
    push_tx(8'h66);
    exp_q.push_back({2'b01, 8'h66});
    start(16'd1, 1'b0, 1'b1);
    wait_idle(200, "t6_done");
    check("final_exp_q", exp_q.size(), 0);
    check("final_rx_q", rx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
